// File: rtl/mem_bridge_pkg.sv
// Shared types and elaboration helpers for the
// CPU line-refill to BRAM bridge.
package mem_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACCESS,
    LAT,
    STALL,
    DONE
  } state_e;

  localparam int CTR_W = 4;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x * 2;
      r = r + 1;
    end
    return r;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  // Parameter legality, evaluated at elaboration time.
  function automatic bit params_ok(
    input int line_w,
    input int depth,
    input int rd_lat,
    input int extra_wait,
    input int addr_w
  );
    return is_pow2(line_w) && (line_w >= 8) &&
           (depth > 1) &&
           (rd_lat >= 1) && (rd_lat <= 4) &&
           (extra_wait >= 0) && (extra_wait <= 15) &&
           (addr_w >= clog2(line_w / 8) + clog2(depth));
  endfunction

endpackage

// File: rtl/bridge_wait_ctr.sv
// Load/decrement wait counter with zero flag,
// shared by the read-latency and stall phases.
module bridge_wait_ctr
  import mem_bridge_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CTR_W-1:0] i_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CTR_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/cache_mem_bridge.sv
// Bridge between the CPU line-refill port and a
// single-port BRAM with latency/wait emulation.
module cache_mem_bridge
  import mem_bridge_pkg::*;
#(
  parameter int LINE_W     = 256,
  parameter int DEPTH      = 64,
  parameter int RD_LAT     = 1,
  parameter int EXTRA_WAIT = 0,
  parameter int ADDR_W     = 32,
  localparam int BE_W      = LINE_W / 8,
  localparam int OFF_W     = clog2(BE_W),
  localparam int IDX_W     = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_req_in,
  input  logic              mem_we_in,
  input  logic [ADDR_W-1:0] mem_addr_in,
  input  logic [LINE_W-1:0] mem_wdata_in,
  input  logic [BE_W-1:0]   mem_be_in,
  output logic [LINE_W-1:0] mem_rdata_out,
  output logic              mem_wait_out,
  output logic              ram_en_out,
  output logic [BE_W-1:0]   ram_we_out,
  output logic [IDX_W-1:0]  ram_addr_out,
  output logic [LINE_W-1:0] ram_wdata_out,
  input  logic [LINE_W-1:0] ram_rdata_in,
  input  logic              hold_in,
  output logic              busy_out,
  output logic              err_out
);

  if (!params_ok(LINE_W, DEPTH, RD_LAT,
                 EXTRA_WAIT, ADDR_W)) begin : g_bad_param
    $error("cache_mem_bridge: parameter out of range");
  end

  localparam logic [CTR_W-1:0] LAT_LD =
    CTR_W'(RD_LAT - 1);
  localparam logic [CTR_W-1:0] STALL_LD =
    CTR_W'((EXTRA_WAIT > 0) ? EXTRA_WAIT - 1 : 0);
  localparam logic [IDX_W:0] DEPTH_L =
    (IDX_W + 1)'(DEPTH);

  state_e r_state;
  state_e w_next;

  logic [IDX_W-1:0]  r_idx;
  logic              r_we;
  logic              r_oor;
  logic              r_err;
  logic [LINE_W-1:0] r_wdata;
  logic [BE_W-1:0]   r_be;
  logic [LINE_W-1:0] r_rdata;

  logic [ADDR_W-1:0] w_hi;
  logic [IDX_W-1:0]  w_idx;
  logic              w_oor;
  logic              w_accept;
  logic              w_ctr_load;
  logic [CTR_W-1:0]  w_ctr_val;
  logic              w_ctr_dec;
  logic              w_ctr_zero;
  logic              w_rd_load;
  logic              w_hit;

  assign w_hi  = mem_addr_in >> (OFF_W + IDX_W);
  assign w_idx = mem_addr_in[OFF_W +: IDX_W];
  assign w_oor = (w_hi != '0) ||
                 ({1'b0, w_idx} >= DEPTH_L);

  assign w_accept = (r_state == IDLE) &&
                    mem_req_in && !hold_in;

  bridge_wait_ctr u_ctr (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_ctr_load),
    .i_val  (w_ctr_val),
    .i_dec  (w_ctr_dec),
    .o_zero (w_ctr_zero)
  );

  always_comb begin
    w_next     = r_state;
    w_ctr_load = 1'b0;
    w_ctr_val  = '0;
    w_ctr_dec  = 1'b0;
    w_rd_load  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) w_next = ACCESS;
      end
      ACCESS: begin
        w_ctr_load = 1'b1;
        if (!r_we) begin
          w_next    = LAT;
          w_ctr_val = LAT_LD;
        end else if (EXTRA_WAIT == 0) begin
          w_next = DONE;
        end else begin
          w_next    = STALL;
          w_ctr_val = STALL_LD;
        end
      end
      LAT: begin
        if (w_ctr_zero) begin
          w_rd_load = 1'b1;
          if (EXTRA_WAIT == 0) begin
            w_next = DONE;
          end else begin
            w_next     = STALL;
            w_ctr_load = 1'b1;
            w_ctr_val  = STALL_LD;
          end
        end else begin
          w_ctr_dec = 1'b1;
        end
      end
      STALL: begin
        if (w_ctr_zero) w_next = DONE;
        else            w_ctr_dec = 1'b1;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_we    <= 1'b0;
      r_oor   <= 1'b0;
      r_err   <= 1'b0;
      r_wdata <= '0;
      r_be    <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_idx   <= w_idx;
        r_we    <= mem_we_in;
        r_oor   <= w_oor;
        r_wdata <= mem_wdata_in;
        r_be    <= mem_be_in;
        if (w_oor) r_err <= 1'b1;
      end
      if (w_rd_load) begin
        r_rdata <= r_oor ? '0 : ram_rdata_in;
      end
    end
  end

  // rst_n gates the strobe so a write in a reset cycle never lands.
  assign w_hit = (r_state == ACCESS) && !r_oor && rst_n;

  assign ram_en_out    = w_hit;
  assign ram_we_out    = (w_hit && r_we) ? r_be : '0;
  assign ram_addr_out  = r_idx;
  assign ram_wdata_out = r_wdata;

  assign mem_rdata_out = r_rdata;
  assign mem_wait_out  = mem_req_in && (r_state != DONE);
  assign busy_out      = (r_state != IDLE);
  assign err_out       = r_err;

endmodule

// File: tb/tb_cache_mem_bridge.sv
// Randomised scoreboard bench for cache_mem_bridge,
// two instances with different latency settings.
module tb_cache_mem_bridge;

  localparam int LW  = 256;
  localparam int BW  = 32;
  localparam int DEP = 64;
  localparam int NI  = 2;
  localparam int RLA [NI] = '{1, 2};
  localparam int EWA [NI] = '{0, 5};

  typedef struct {
    int          t_done;
    logic [LW-1:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          rst_n     [NI];
  logic          req       [NI];
  logic          we        [NI];
  logic          hold      [NI];
  logic [31:0]   addr      [NI];
  logic [LW-1:0] wdata     [NI];
  logic [BW-1:0] be        [NI];
  logic [LW-1:0] rdata     [NI];
  logic          wt        [NI];
  logic          ram_en    [NI];
  logic [BW-1:0] ram_we    [NI];
  logic [5:0]    ram_addr  [NI];
  logic [LW-1:0] ram_wdata [NI];
  logic [LW-1:0] ram_rdata [NI];
  logic          busy      [NI];
  logic          err       [NI];

  logic [LW-1:0] ref_mem [NI][DEP];
  logic [LW-1:0] ref_rd  [NI];
  logic          ref_err [NI];

  int            cur_t0   [NI];
  int            cur_line [NI];
  logic          cur_ok   [NI];
  logic          cur_we   [NI];
  logic [BW-1:0] cur_be   [NI];

  exp_t sb0 [$];
  exp_t sb1 [$];

  int checks = 0;
  int errors = 0;

  function automatic logic [LW-1:0] init_line(input int k, input int i);
    logic [LW-1:0] v;
    for (int w = 0; w < 8; w++) begin
      v[w*32 +: 32] = (32'(i * 8 + w + 1) * 32'h9E37_79B9) ^
                      (32'(k) << 28);
    end
    return v;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int RL = RLA[g];
    logic [LW-1:0] bram [DEP];
    logic [LW-1:0] pipe [RL];

    cache_mem_bridge #(
      .LINE_W(LW), .DEPTH(DEP), .RD_LAT(RL),
      .EXTRA_WAIT(EWA[g]), .ADDR_W(32)
    ) u_dut (
      .clk           (clk),
      .rst_n         (rst_n[g]),
      .mem_req_in    (req[g]),
      .mem_we_in     (we[g]),
      .mem_addr_in   (addr[g]),
      .mem_wdata_in  (wdata[g]),
      .mem_be_in     (be[g]),
      .mem_rdata_out (rdata[g]),
      .mem_wait_out  (wt[g]),
      .ram_en_out    (ram_en[g]),
      .ram_we_out    (ram_we[g]),
      .ram_addr_out  (ram_addr[g]),
      .ram_wdata_out (ram_wdata[g]),
      .ram_rdata_in  (ram_rdata[g]),
      .hold_in       (hold[g]),
      .busy_out      (busy[g]),
      .err_out       (err[g])
    );

    initial begin
      for (int i = 0; i < DEP; i++) bram[i] <= init_line(g, i);
    end

    // BRAM stand-in: garbage on idle cycles exposes mistimed sampling.
    always @(posedge clk) begin
      if (ram_en[g]) begin
        for (int b = 0; b < BW; b++) begin
          if (ram_we[g][b])
            bram[ram_addr[g]][b*8 +: 8] <= ram_wdata[g][b*8 +: 8];
        end
      end
      pipe[0] <= ram_en[g] ? bram[ram_addr[g]] : {8{$urandom}};
      for (int s = 1; s < RL; s++) pipe[s] <= pipe[s-1];
    end

    assign ram_rdata[g] = pipe[RL-1];
  end

  task automatic chk(input string nm, input logic [LW-1:0] act,
                     input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every wait-low pulse.
  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      exp_t e;
      bit   exp_en;
      if (req[k] && !wt[k]) begin
        if ((k == 0 ? sb0.size() : sb1.size()) == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: inst %0d cycle %0d", k, cyc);
        end else begin
          e = (k == 0) ? sb0.pop_front() : sb1.pop_front();
          chk("done_cycle", LW'(cyc), LW'(e.t_done));
          chk("rdata", rdata[k], e.rdata);
          chk("err_at_done", LW'(err[k]), LW'(e.err));
        end
      end
      exp_en = cur_ok[k] && (cyc == cur_t0[k] + 1);
      if (ram_en[k] || exp_en) begin
        chk("ram_en", LW'(ram_en[k]), LW'(exp_en));
        chk("ram_addr", LW'(ram_addr[k]), LW'(cur_line[k]));
        chk("ram_we", LW'(ram_we[k]),
            LW'(cur_we[k] ? cur_be[k] : '0));
      end
    end
  end

  function automatic int lat_of(input int k, input bit w);
    return w ? 2 + EWA[k] : 2 + RLA[k] + EWA[k];
  endfunction

  task automatic access(input int k, input bit w, input logic [31:0] a,
                        input logic [LW-1:0] d, input logic [BW-1:0] m,
                        input int gap, input int hc, input int drop);
    int          lat;
    int          t0;
    logic [31:0] ln;
    bit          oor;
    bit          fin;
    exp_t        e;
    lat = lat_of(k, w);
    repeat (gap) begin
      @(posedge clk); #1;
      req[k]  = 1'b0;
      hold[k] = 1'($urandom);
    end
    @(posedge clk); #1;
    we[k] = w; addr[k] = a; wdata[k] = d; be[k] = m;
    req[k] = 1'b1;
    hold[k] = (hc > 0);
    for (int j = 0; j < hc; j++) begin
      @(negedge clk);
      chk("hold_busy", LW'(busy[k]), LW'(0));
      chk("hold_wait", LW'(wt[k]), LW'(1));
      @(posedge clk); #1;
    end
    hold[k] = 1'b0;
    t0 = cyc;
    ln = a / BW;
    oor = (ln >= DEP);
    if (oor) ref_err[k] = 1'b1;
    if (w && !oor) begin
      for (int b = 0; b < BW; b++)
        if (m[b]) ref_mem[k][int'(ln)][b*8 +: 8] = d[b*8 +: 8];
    end
    if (!w) ref_rd[k] = oor ? '0 : ref_mem[k][int'(ln)];
    cur_t0[k] = t0;
    cur_line[k] = oor ? 0 : int'(ln);
    cur_ok[k] = !oor;
    cur_we[k] = w;
    cur_be[k] = m;
    if (drop == 0) begin
      e.t_done = t0 + lat;
      e.rdata = ref_rd[k];
      e.err = ref_err[k];
      if (k == 0) sb0.push_back(e);
      else        sb1.push_back(e);
    end
    fin = 1'b0;
    for (int i = 1; i <= lat + 4 && !fin; i++) begin
      @(posedge clk); #1;
      hold[k] = 1'($urandom);
      if (drop != 0 && i == drop) req[k] = 1'b0;
      @(negedge clk);
      if (i == 1) chk("err_sticky", LW'(err[k]), LW'(ref_err[k]));
      if (drop == 0) fin = req[k] && !wt[k];
      else           fin = !busy[k];
    end
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL timeout: inst %0d accepted at %0d", k, t0);
    end
  endtask

  task automatic reset_write(input int k, input logic [31:0] a);
    @(posedge clk); #1;
    req[k] = 1'b0;
    hold[k] = 1'b0;
    @(posedge clk); #1;
    we[k] = 1'b1; addr[k] = a; wdata[k] = '1; be[k] = '1;
    req[k] = 1'b1;
    cur_ok[k] = 1'b0;
    @(posedge clk); #1;
    rst_n[k] = 1'b0;
    @(negedge clk);
    chk("rst_access_we", LW'(ram_we[k]), LW'(0));
    chk("rst_access_en", LW'(ram_en[k]), LW'(0));
    @(posedge clk); #1;
    rst_n[k] = 1'b1;
    req[k] = 1'b0;
    ref_err[k] = 1'b0;
    ref_rd[k] = '0;
    @(negedge clk);
    chk("rst_rdata", rdata[k], '0);
    chk("rst_err", LW'(err[k]), LW'(0));
    chk("rst_busy", LW'(busy[k]), LW'(0));
    chk("rst_ram_en", LW'(ram_en[k]), LW'(0));
    chk("rst_ram_we", LW'(ram_we[k]), LW'(0));
    chk("rst_ram_addr", LW'(ram_addr[k]), LW'(0));
    chk("rst_ram_wdata", ram_wdata[k], '0);
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      rst_n[k] = 1'b0; req[k] = 1'b0; we[k] = 1'b0;
      hold[k] = 1'b0; addr[k] = '0; wdata[k] = '0; be[k] = '0;
      ref_err[k] = 1'b0; ref_rd[k] = '0;
      cur_ok[k] = 1'b0; cur_t0[k] = -10; cur_line[k] = 0;
      cur_we[k] = 1'b0; cur_be[k] = '0;
      for (int i = 0; i < DEP; i++) ref_mem[k][i] = init_line(k, i);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk("init_rdata", rdata[k], '0);
      chk("init_err", LW'(err[k]), LW'(0));
      chk("init_busy", LW'(busy[k]), LW'(0));
      chk("init_ram_en", LW'(ram_en[k]), LW'(0));
      chk("init_ram_we", LW'(ram_we[k]), LW'(0));
      chk("init_ram_addr", LW'(ram_addr[k]), LW'(0));
      chk("init_ram_wdata", ram_wdata[k], '0);
    end
    @(posedge clk); #1;
    for (int k = 0; k < NI; k++) rst_n[k] = 1'b1;

    for (int k = 0; k < NI; k++) begin
      access(k, 0, 32'h60, '0, '0, 1, 0, 0);
      access(k, 1, 32'h20, {32{8'hAA}}, 32'h0000_000F, 1, 0, 0);
      access(k, 0, 32'h20, '0, '0, 0, 0, 0);
      access(k, 0, 32'h0, '0, '0, 1, 0, 0);
      access(k, 0, 32'h20, '0, '0, 0, 0, 0);
      access(k, 0, 32'h800, '0, '0, 1, 0, 0);
      access(k, 0, 32'h60, '0, '0, 1, 20, 0);
      reset_write(k, 32'h40);
      access(k, 0, 32'h40, '0, '0, 1, 0, 0);
      for (int n = 0; n < 60; n++) begin
        bit          w;
        int          ln;
        logic [31:0] a;
        int          drop;
        w = 1'($urandom);
        ln = ($urandom % 16 == 0) ? 64 + int'($urandom % 8)
                                  : int'($urandom % DEP);
        a = 32'(ln * BW) + ($urandom % BW);
        if ($urandom % 16 == 0) a = a | (32'h1 << (12 + $urandom % 20));
        drop = 0;
        if ($urandom % 8 == 0)
          drop = 1 + int'($urandom % (lat_of(k, w) - 1));
        access(k, w, a, {8{$urandom}}, $urandom,
               int'($urandom % 3), 0, drop);
      end
      access(k, 0, 32'h20, '0, '0, 1, 0, 0);
    end

    repeat (5) @(posedge clk);
    checks++;
    if (sb0.size() + sb1.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d entries left",
               sb0.size() + sb1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
